// File: rtl/regfile_wb_scheduler.sv
// Writeback scheduler and scoreboard: round-robin shares the register-file write
// port between ALU/LSU/MDU and stalls issue on RAW/WAW hazards against pending writes.
module regfile_wb_scheduler #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid,
  input  logic            issue_we,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      issue_rs1,
  input  logic [4:0]      issue_rs2,
  output logic            issue_stall,
  input  logic            alu_valid,
  input  logic            lsu_valid,
  input  logic            mdu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [4:0]      lsu_rd,
  input  logic [4:0]      mdu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic [XLEN-1:0] lsu_data,
  input  logic [XLEN-1:0] mdu_data,
  output logic            alu_ready,
  output logic            lsu_ready,
  output logic            mdu_ready,
  output logic            write_reg,
  output logic [4:0]      dstreg_addr,
  output logic [XLEN-1:0] dstreg_data,
  output logic [31:0]     busy
);

  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_LSU = 2'd1,
    SRC_MDU = 2'd2
  } src_e;

  src_e            ptr_q, ptr_d;
  logic [31:0]     busy_q, busy_d;
  logic            write_reg_q, write_reg_d;
  logic [4:0]      addr_q, addr_d;
  logic [XLEN-1:0] data_q, data_d;

  logic [2:0]      grant_s;
  logic            hs_s;
  logic [4:0]      hs_rd_s;
  logic [XLEN-1:0] hs_data_s;
  logic            issue_set_s;
  logic [31:0]     set_mask_s;
  logic [31:0]     clr_mask_s;

  // Grants are suppressed while reset is asserted so no handshake can complete.
  always_comb begin
    grant_s = 3'b000;
    if (!rst_n) begin
      grant_s = 3'b000;
    end else begin
      case (ptr_q)
        SRC_LSU: begin
          if (lsu_valid)      grant_s = 3'b010;
          else if (mdu_valid) grant_s = 3'b100;
          else if (alu_valid) grant_s = 3'b001;
          else                grant_s = 3'b000;
        end
        SRC_MDU: begin
          if (mdu_valid)      grant_s = 3'b100;
          else if (alu_valid) grant_s = 3'b001;
          else if (lsu_valid) grant_s = 3'b010;
          else                grant_s = 3'b000;
        end
        default: begin
          if (alu_valid)      grant_s = 3'b001;
          else if (lsu_valid) grant_s = 3'b010;
          else if (mdu_valid) grant_s = 3'b100;
          else                grant_s = 3'b000;
        end
      endcase
    end
  end

  assign alu_ready = grant_s[0];
  assign lsu_ready = grant_s[1];
  assign mdu_ready = grant_s[2];
  assign hs_s      = |grant_s;

  always_comb begin
    hs_rd_s   = 5'd0;
    hs_data_s = {XLEN{1'b0}};
    ptr_d     = ptr_q;
    case (grant_s)
      3'b001: begin
        hs_rd_s   = alu_rd;
        hs_data_s = alu_data;
        ptr_d     = SRC_LSU;
      end
      3'b010: begin
        hs_rd_s   = lsu_rd;
        hs_data_s = lsu_data;
        ptr_d     = SRC_MDU;
      end
      3'b100: begin
        hs_rd_s   = mdu_rd;
        hs_data_s = mdu_data;
        ptr_d     = SRC_ALU;
      end
      default: begin
        hs_rd_s   = 5'd0;
        hs_data_s = {XLEN{1'b0}};
        ptr_d     = ptr_q;
      end
    endcase
  end

  assign issue_stall = issue_valid &&
                       (busy_q[issue_rs1] || busy_q[issue_rs2] || (issue_we && busy_q[issue_rd]));
  assign issue_set_s = issue_valid && !issue_stall && issue_we && (issue_rd != 5'd0);

  // Set is applied after clear so a same-cycle collision leaves the bit set.
  always_comb begin
    set_mask_s  = issue_set_s ? (32'd1 << issue_rd) : 32'd0;
    clr_mask_s  = (hs_s && (hs_rd_s != 5'd0)) ? (32'd1 << hs_rd_s) : 32'd0;
    busy_d      = ((busy_q & ~clr_mask_s) | set_mask_s) & ~32'd1;
    write_reg_d = hs_s && (hs_rd_s != 5'd0);
    addr_d      = hs_s ? hs_rd_s : addr_q;
    data_d      = hs_s ? hs_data_s : data_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q       <= SRC_ALU;
      busy_q      <= 32'd0;
      write_reg_q <= 1'b0;
      addr_q      <= 5'd0;
      data_q      <= {XLEN{1'b0}};
    end else begin
      ptr_q       <= ptr_d;
      busy_q      <= busy_d;
      write_reg_q <= write_reg_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
    end
  end

  assign write_reg   = write_reg_q;
  assign dstreg_addr = addr_q;
  assign dstreg_data = data_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed and randomized bench for regfile_wb_scheduler, checked against a
// cycle-level scoreboard/arbiter model kept in plain bench variables.
module tb_regfile_wb_scheduler;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic            issue_valid, issue_we;
  logic [4:0]      issue_rd, issue_rs1, issue_rs2;
  logic            issue_stall;
  logic            alu_ready, lsu_ready, mdu_ready;
  logic            write_reg;
  logic [4:0]      dstreg_addr;
  logic [XLEN-1:0] dstreg_data;
  logic [31:0]     busy;

  logic            sv    [3];
  logic [4:0]      srd   [3];
  logic [XLEN-1:0] sdata [3];

  // model state
  logic [31:0]     m_busy;
  int              m_ptr;
  logic            m_wr;
  logic [4:0]      m_addr;
  logic [XLEN-1:0] m_data;
  logic            m_stall;
  logic [2:0]      obs_rdy;
  logic            obs_stall;
  bit              auto_drop;

  int checks;
  int errors;

  regfile_wb_scheduler #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_we(issue_we), .issue_rd(issue_rd),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_stall(issue_stall),
    .alu_valid(sv[0]), .lsu_valid(sv[1]), .mdu_valid(sv[2]),
    .alu_rd(srd[0]), .lsu_rd(srd[1]), .mdu_rd(srd[2]),
    .alu_data(sdata[0]), .lsu_data(sdata[1]), .mdu_data(sdata[2]),
    .alu_ready(alu_ready), .lsu_ready(lsu_ready), .mdu_ready(mdu_ready),
    .write_reg(write_reg), .dstreg_addr(dstreg_addr), .dstreg_data(dstreg_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check combinational outputs, advance the model, check registered outputs.
  task automatic cycle();
    int g;
    logic [2:0] exp_rdy;
    logic [31:0] nb;
    #1;
    m_stall = issue_valid && (m_busy[issue_rs1] || m_busy[issue_rs2] ||
                              (issue_we && m_busy[issue_rd]));
    g = -1;
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        if (g < 0 && sv[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
      end
    end
    exp_rdy = (g >= 0) ? (3'b001 << g) : 3'b000;
    obs_rdy   = {mdu_ready, lsu_ready, alu_ready};
    obs_stall = issue_stall;
    chk("issue_stall", 64'(issue_stall), 64'(m_stall));
    chk("ready", 64'(obs_rdy), 64'(exp_rdy));
    if (!rst_n) begin
      m_busy = 32'd0; m_ptr = 0; m_wr = 1'b0; m_addr = 5'd0; m_data = 32'd0;
    end else begin
      nb = m_busy;
      if (g >= 0 && srd[g] != 5'd0) nb[srd[g]] = 1'b0;
      if (issue_valid && !m_stall && issue_we && issue_rd != 5'd0) nb[issue_rd] = 1'b1;
      m_busy = nb;
      m_wr = (g >= 0) && (srd[g] != 5'd0);
      if (g >= 0) begin
        m_addr = srd[g];
        m_data = sdata[g];
        m_ptr  = (g + 1) % 3;
      end
    end
    @(posedge clk);
    #1;
    chk("busy", 64'(busy), 64'(m_busy));
    chk("write_reg", 64'(write_reg), 64'(m_wr));
    chk("dstreg_addr", 64'(dstreg_addr), 64'(m_addr));
    chk("dstreg_data", 64'(dstreg_data), 64'(m_data));
    if (auto_drop && g >= 0) sv[g] = 1'b0;
  endtask

  initial begin
    logic [2:0] rr_seq [3];
    rr_seq[0] = 3'b001; rr_seq[1] = 3'b010; rr_seq[2] = 3'b100;
    checks = 0; errors = 0; auto_drop = 1'b0;
    clk = 1'b0; rst_n = 1'b0;
    issue_valid = 1'b0; issue_we = 1'b0; issue_rd = 5'd0; issue_rs1 = 5'd0; issue_rs2 = 5'd0;
    m_busy = 32'd0; m_ptr = 0; m_wr = 1'b0; m_addr = 5'd0; m_data = 32'd0;
    for (int i = 0; i < 3; i++) begin
      sv[i] = 1'b1; srd[i] = 5'(i + 1); sdata[i] = 32'h100 + 32'(i);
    end

    // Reset with all sources valid
    cycle();
    cycle();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_write_reg", 64'(write_reg), 64'd0);
    rst_n = 1'b1;

    // Round-robin with all three continuously valid; first grant is ALU
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("rr_grant", 64'(obs_rdy), 64'(rr_seq[i % 3]));
    end
    for (int i = 0; i < 3; i++) sv[i] = 1'b0;

    // RAW stall on r5 until the LSU writes it back
    issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd5;
    cycle();
    chk("raw_busy5", 64'(busy[5]), 64'd1);
    issue_we = 1'b0; issue_rd = 5'd0; issue_rs1 = 5'd5;
    cycle();
    chk("raw_stall", 64'(obs_stall), 64'd1);
    sv[1] = 1'b1; srd[1] = 5'd5; sdata[1] = 32'hDEADBEEF;
    cycle();
    chk("raw_stall_n", 64'(obs_stall), 64'd1);
    sv[1] = 1'b0;
    chk("raw_wr", 64'(write_reg), 64'd1);
    chk("raw_addr", 64'(dstreg_addr), 64'd5);
    chk("raw_data", 64'(dstreg_data), 64'hDEADBEEF);
    cycle();
    chk("raw_unstall", 64'(obs_stall), 64'd0);

    // WAW stall on r7 against a pending MDU write
    issue_we = 1'b1; issue_rd = 5'd7; issue_rs1 = 5'd0;
    cycle();
    cycle();
    chk("waw_stall", 64'(obs_stall), 64'd1);
    sv[2] = 1'b1; srd[2] = 5'd7; sdata[2] = 32'h7777_0007;
    cycle();
    chk("waw_stall_hs", 64'(obs_stall), 64'd1);
    sv[2] = 1'b0;
    cycle();
    chk("waw_accept", 64'(obs_stall), 64'd0);
    chk("waw_busy7", 64'(busy[7]), 64'd1);

    // x0: issue rd=0 and ALU writeback to x0
    issue_rd = 5'd0;
    cycle();
    issue_valid = 1'b0;
    sv[0] = 1'b1; srd[0] = 5'd0; sdata[0] = 32'h0000_0123;
    cycle();
    chk("x0_ready", 64'(obs_rdy[0]), 64'd1);
    chk("x0_no_write", 64'(write_reg), 64'd0);
    sv[0] = 1'b0;

    // Reset in the same cycle as an LSU handshake
    issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd9;
    cycle();
    issue_valid = 1'b0;
    sv[1] = 1'b1; srd[1] = 5'd9; sdata[1] = 32'h9999_9999;
    rst_n = 1'b0;
    cycle();
    chk("mid_rst_wr", 64'(write_reg), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1; sv[1] = 1'b0;
    cycle();

    // Randomized traffic respecting the hold-until-ready source protocol
    auto_drop = 1'b1;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (!sv[i] && $urandom_range(0, 1) == 1) begin
          sv[i] = 1'b1; srd[i] = 5'($urandom_range(0, 7)); sdata[i] = $urandom;
        end
      end
      issue_valid = 1'($urandom_range(0, 1));
      issue_we    = 1'($urandom_range(0, 1));
      issue_rd    = 5'($urandom_range(0, 7));
      issue_rs1   = 5'($urandom_range(0, 7));
      issue_rs2   = 5'($urandom_range(0, 7));
      rst_n       = ($urandom_range(0, 63) != 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
